// File: rtl/rfphoenix_alu_arb.sv
// Round-robin arbiter plus issue stage sharing one ALU among NREQ requesters.
// Define RFPHOENIX_ALU_ARB_OUTREG_EN to add a registered result stage (latency 2).

package rfphoenix_alu_arb_pkg;
  typedef logic [31:0] value_t;

  typedef struct packed {
    logic [5:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [10:0] func;
  } instruction_t;

  localparam logic [5:0]  OP_R2    = 6'h00;
  localparam logic [5:0]  OP_ADDI  = 6'h08;
  localparam logic [10:0] OP_R1    = 11'h001;
  localparam logic [4:0]  OP_PEEKQ = 5'h01;
  localparam logic [4:0]  OP_POPQ  = 5'h02;
  localparam logic [4:0]  OP_STATQ = 5'h03;
endpackage

module rfphoenix_alu_arb
  import rfphoenix_alu_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int TAGW = $clog2(NREQ)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  instruction_t [NREQ-1:0]    req_ir,
  input  value_t [NREQ-1:0]          req_a,
  input  value_t [NREQ-1:0]          req_b,
  input  value_t [NREQ-1:0]          req_c,
  input  value_t [NREQ-1:0]          req_t,
  input  value_t [NREQ-1:0]          req_imm,
  output instruction_t               alu_ir,
  output value_t                     alu_a,
  output value_t                     alu_b,
  output value_t                     alu_c,
  output value_t                     alu_t,
  output value_t                     alu_imm,
  input  value_t                     alu_o,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [TAGW-1:0]            res_tag,
  output value_t                     res_o,
  output logic                       trace_pop
);

  function automatic logic is_popq(input logic [5:0] opcode, input logic [10:0] func,
                                   input logic [4:0] rb, input logic [3:0] imm_lo);
    return (opcode == OP_R2) && (func == OP_R1) && (rb == OP_POPQ) && (imm_lo == 4'hF);
  endfunction

  logic [NREQ-1:0] grant;
  logic [TAGW-1:0] grant_tag;
  logic            any_grant;
  logic [TAGW-1:0] last_grant;
  logic [TAGW-1:0] rr_tag;
  int              rr_idx;

  logic            s1_retire;
  logic            s1_adv;
  logic            accept;

  logic            vld_p1;
  logic [TAGW-1:0] tag_p1;
  instruction_t    ir_p1;
  value_t          a_p1;
  value_t          b_p1;
  value_t          c_p1;
  value_t          t_p1;
  value_t          imm_p1;

  // Scan starts one past the last accepted requester, so a stalled winner keeps its turn.
  always_comb begin
    grant     = '0;
    grant_tag = '0;
    any_grant = 1'b0;
    rr_idx    = 0;
    rr_tag    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      rr_idx = (int'(last_grant) + k) % NREQ;
      rr_tag = TAGW'(rr_idx);
      if (!any_grant && req_valid[rr_tag]) begin
        any_grant     = 1'b1;
        grant[rr_tag] = 1'b1;
        grant_tag     = rr_tag;
      end
    end
  end

`ifdef RFPHOENIX_ALU_ARB_OUTREG_EN
  logic            vld_p2;
  logic [TAGW-1:0] tag_p2;
  value_t          res_p2;

  assign s1_retire = vld_p1 & (~vld_p2 | res_ready);
`else
  assign s1_retire = vld_p1 & res_ready;
`endif

  // Gating with rst_n keeps req_ready low for the whole reset window.
  assign s1_adv    = rst_n & (~vld_p1 | s1_retire);
  assign accept    = any_grant & s1_adv;
  assign req_ready = s1_adv ? grant : '0;

  // ---- p0 -> p1: issue stage capture ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1     <= 1'b0;
      tag_p1     <= '0;
      ir_p1      <= '0;
      a_p1       <= '0;
      b_p1       <= '0;
      c_p1       <= '0;
      t_p1       <= '0;
      imm_p1     <= '0;
      last_grant <= TAGW'(NREQ - 1);
    end else begin
      if (s1_adv) vld_p1 <= accept;
      if (accept) begin
        tag_p1     <= grant_tag;
        ir_p1      <= req_ir[grant_tag];
        a_p1       <= req_a[grant_tag];
        b_p1       <= req_b[grant_tag];
        c_p1       <= req_c[grant_tag];
        t_p1       <= req_t[grant_tag];
        imm_p1     <= req_imm[grant_tag];
        last_grant <= grant_tag;
      end
    end
  end

  assign alu_ir  = ir_p1;
  assign alu_a   = a_p1;
  assign alu_b   = b_p1;
  assign alu_c   = c_p1;
  assign alu_t   = t_p1;
  assign alu_imm = imm_p1;

  // Strobe only on the retiring edge, so a POPQ held in S1 pops exactly once.
  assign trace_pop = s1_retire & is_popq(ir_p1.opcode, ir_p1.func, ir_p1.rb, imm_p1[3:0]);

`ifdef RFPHOENIX_ALU_ARB_OUTREG_EN
  // ---- p1 -> p2: result register, unload and reload on the same edge ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2 <= 1'b0;
      tag_p2 <= '0;
      res_p2 <= '0;
    end else if (s1_retire) begin
      vld_p2 <= 1'b1;
      tag_p2 <= tag_p1;
      res_p2 <= alu_o;
    end else if (res_ready) begin
      vld_p2 <= 1'b0;
    end
  end

  assign res_valid = vld_p2;
  assign res_tag   = tag_p2;
  assign res_o     = res_p2;
`else
  assign res_valid = vld_p1;
  assign res_tag   = tag_p1;
  assign res_o     = alu_o;
`endif

endmodule

// File: tb/tb_rfphoenix_alu_arb.sv
// Scoreboard bench for rfphoenix_alu_arb: directed vectors, monitor pops expected results.
`timescale 1ns/1ps
module tb_rfphoenix_alu_arb;
  import rfphoenix_alu_arb_pkg::*;

  localparam int NREQ = 4;
  localparam int TAGW = 2;
`ifdef RFPHOENIX_ALU_ARB_OUTREG_EN
  localparam int LAT      = 2;
  localparam int MAXACC   = 2;
  localparam int POPQ_REQ = 1;
`else
  localparam int LAT      = 1;
  localparam int MAXACC   = 1;
  localparam int POPQ_REQ = 0;
`endif

  logic                    clk;
  logic                    rst_n;
  logic [NREQ-1:0]         req_valid;
  logic [NREQ-1:0]         req_ready;
  instruction_t [NREQ-1:0] req_ir;
  value_t [NREQ-1:0]       req_a, req_b, req_c, req_t, req_imm;
  instruction_t            alu_ir;
  value_t                  alu_a, alu_b, alu_c, alu_t, alu_imm, alu_o;
  logic                    res_valid, res_ready, trace_pop;
  logic [TAGW-1:0]         res_tag;
  value_t                  res_o;

  rfphoenix_alu_arb #(.NREQ(NREQ), .TAGW(TAGW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_ir(req_ir), .req_a(req_a), .req_b(req_b), .req_c(req_c), .req_t(req_t), .req_imm(req_imm),
    .alu_ir(alu_ir), .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c), .alu_t(alu_t), .alu_imm(alu_imm),
    .alu_o(alu_o),
    .res_valid(res_valid), .res_ready(res_ready), .res_tag(res_tag), .res_o(res_o),
    .trace_pop(trace_pop)
  );

  // ALU stand-in: ADDI adds the immediate, everything else adds a and b.
  always_comb alu_o = (alu_ir.opcode == OP_ADDI) ? alu_a + alu_imm : alu_a + alu_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int     n_checks = 0;
  int     n_fail   = 0;
  int     pop_cnt  = 0;
  int     exp_tag[$];
  value_t exp_val[$];
  int     acc_q[$];
  value_t exp_res[NREQ];
  logic   hold_prev = 1'b0;
  value_t prev_o;
  logic [TAGW-1:0] prev_tag;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic instruction_t mk_ir(input logic [5:0] op, input logic [10:0] fn, input logic [4:0] rb);
    instruction_t ir;
    ir = '0;
    ir.opcode = op;
    ir.func   = fn;
    ir.rb     = rb;
    return ir;
  endfunction

  task automatic set_req(input int i, input instruction_t ir, input value_t a, input value_t b,
                         input value_t imm, input value_t res);
    req_ir[i]  = ir;
    req_a[i]   = a;
    req_b[i]   = b;
    req_c[i]   = 32'hC0 + 32'(i);
    req_t[i]   = 32'h70 + 32'(i);
    req_imm[i] = imm;
    exp_res[i] = res;
  endtask

  // Runs ncyc cycles; each acceptance queues that requester's expected result.
  task automatic serve(input int ncyc, input bit keep);
    logic [NREQ-1:0] g;
    int t;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      g = req_ready & req_valid;
      t = -1;
      for (int i = 0; i < NREQ; i++) if (g[i]) t = i;
      if (t >= 0) begin
        acc_q.push_back(t);
        exp_tag.push_back(t);
        exp_val.push_back(exp_res[t]);
      end
      @(posedge clk); #1;
      if (t >= 0 && !keep) req_valid[t] = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_tag.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", 64'(exp_tag.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    exp_tag.delete();
    exp_val.delete();
    acc_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // Monitor: one-hot grant, result scoreboard, hold stability, pop/retire coincidence.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("ready_onehot0", {63'b0, $onehot0(req_ready)}, 64'd1);
      if (res_valid && res_ready) begin
        if (exp_tag.size() == 0) begin
          chk("res_unexpected", {63'b0, res_valid}, 64'd0);
        end else begin
          chk("res_tag", {62'b0, res_tag}, 64'(exp_tag.pop_front()));
          chk("res_o", {32'b0, res_o}, {32'b0, exp_val.pop_front()});
        end
      end
      if (hold_prev) begin
        chk("hold_valid", {63'b0, res_valid}, 64'd1);
        chk("hold_o", {32'b0, res_o}, {32'b0, prev_o});
        chk("hold_tag", {62'b0, res_tag}, {62'b0, prev_tag});
      end
      if (trace_pop) begin
        pop_cnt++;
`ifdef RFPHOENIX_ALU_ARB_OUTREG_EN
        chk("pop_on_retire", {63'b0, (!res_valid || res_ready)}, 64'd1);
`else
        chk("pop_on_retire", {63'b0, (res_valid && res_ready)}, 64'd1);
`endif
      end
    end
    hold_prev = rst_n && res_valid && !res_ready;
    prev_o    = res_o;
    prev_tag  = res_tag;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d;
    rst_n     = 1'b0;
    res_ready = 1'b1;
    req_valid = '1;
    for (int i = 0; i < NREQ; i++) set_req(i, '0, '0, '0, '0, '0);

    // Reset state, with requests present
    #3;
    chk("rst_req_ready", {60'b0, req_ready}, 64'd0);
    chk("rst_res_valid", {63'b0, res_valid}, 64'd0);
    chk("rst_res_tag", {62'b0, res_tag}, 64'd0);
    chk("rst_res_o", {32'b0, res_o}, 64'd0);
    chk("rst_trace_pop", {63'b0, trace_pop}, 64'd0);
    chk("rst_alu_a", {32'b0, alu_a}, 64'd0);
    chk("rst_alu_ir", {32'b0, alu_ir}, 64'd0);
    req_valid = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single requester: ADDI 5+7 from requester 2
    set_req(2, mk_ir(OP_ADDI, '0, '0), 32'd5, 32'd0, 32'd7, 32'd12);
    req_valid = 4'b0100;
    @(negedge clk);
    chk("single_ready", {60'b0, req_ready}, 64'h4);
    exp_tag.push_back(2);
    exp_val.push_back(32'd12);
    @(posedge clk); #1;
    req_valid = '0;
    d = 0;
    do begin
      @(negedge clk);
      d++;
    end while (!res_valid && d < 8);
    chk("single_latency", 64'(d), 64'(LAT));
    @(negedge clk);
    chk("single_one_cycle", {63'b0, res_valid}, 64'd0);
    @(posedge clk); #1;

    // Fairness: all four continuously valid for 8 cycles
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, mk_ir(OP_ADDI, '0, '0), 32'd10 + 32'(i), 32'd0, 32'd100, 32'd110 + 32'(i));
    req_valid = '1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("fair_grant", {60'b0, req_ready}, 64'(1 << (k % 4)));
      exp_tag.push_back(k % 4);
      exp_val.push_back(32'd110 + 32'(k % 4));
      @(posedge clk); #1;
    end
    req_valid = '0;
    wait_drain();

    // Backpressure: res_ready low 5 cycles with 3 pending
    do_reset();
    res_ready = 1'b0;
    for (int i = 0; i < 3; i++) set_req(i, mk_ir(OP_ADDI, '0, '0), 32'd20 + 32'(i), 32'd0, 32'd1, 32'd21 + 32'(i));
    req_valid = 4'b0111;
    serve(5, 1'b0);
    chk("bp_accepted", 64'(acc_q.size()), 64'(MAXACC));
    @(negedge clk);
    chk("bp_ready_zero", {60'b0, req_ready}, 64'd0);
    @(posedge clk); #1;
    res_ready = 1'b1;
    serve(10, 1'b0);
    chk("bp_total", 64'(acc_q.size()), 64'd3);
    if (acc_q.size() == 3) begin
      chk("bp_order0", 64'(acc_q[0]), 64'd0);
      chk("bp_order1", 64'(acc_q[1]), 64'd1);
      chk("bp_order2", 64'(acc_q[2]), 64'd2);
    end
    wait_drain();

    // POPQ imm=15 held in S1 while output stalls, then released
    do_reset();
    res_ready = 1'b0;
    set_req(1 - POPQ_REQ, mk_ir(OP_ADDI, '0, '0), 32'd1, 32'd0, 32'd2, 32'd3);
    set_req(POPQ_REQ, mk_ir(OP_R2, OP_R1, OP_POPQ), 32'd7, 32'd1, 32'd15, 32'd8);
    req_valid = 4'b0011;
    pop_cnt = 0;
    serve(4, 1'b0);
    chk("popq_stalled_no_pop", 64'(pop_cnt), 64'd0);
    res_ready = 1'b1;
    serve(6, 1'b0);
    wait_drain();
    chk("popq_one_pulse", 64'(pop_cnt), 64'd1);

    // POPQ imm=3, PEEKQ imm=15, STATQ imm=15: no pops
    set_req(0, mk_ir(OP_R2, OP_R1, OP_STATQ), 32'd2, 32'd2, 32'd15, 32'd4);
    set_req(2, mk_ir(OP_R2, OP_R1, OP_POPQ), 32'd4, 32'd4, 32'd3, 32'd8);
    set_req(3, mk_ir(OP_R2, OP_R1, OP_PEEKQ), 32'd5, 32'd5, 32'd15, 32'd10);
    req_valid = 4'b1101;
    serve(6, 1'b0);
    wait_drain();
    chk("nonpop_no_pulse", 64'(pop_cnt), 64'd1);

    // Reset while both stages are full
    do_reset();
    res_ready = 1'b0;
    for (int i = 0; i < NREQ; i++) set_req(i, mk_ir(OP_ADDI, '0, '0), 32'd30 + 32'(i), 32'd0, 32'd5, 32'd35 + 32'(i));
    req_valid = '1;
    serve(4, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midrst_res_valid", {63'b0, res_valid}, 64'd0);
    chk("midrst_res_tag", {62'b0, res_tag}, 64'd0);
    chk("midrst_res_o", {32'b0, res_o}, 64'd0);
    chk("midrst_trace_pop", {63'b0, trace_pop}, 64'd0);
    chk("midrst_req_ready", {60'b0, req_ready}, 64'd0);
    chk("midrst_alu_imm", {32'b0, alu_imm}, 64'd0);
    exp_tag.delete();
    exp_val.delete();
    acc_q.delete();
    res_ready = 1'b1;
    req_valid = '1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    serve(4, 1'b1);
    chk("midrst_first_grant", 64'(acc_q.size() > 0 ? acc_q[0] : -1), 64'd0);
    req_valid = '0;
    wait_drain();

    // Stalled requester keeps its turn over a later arrival
    do_reset();
    res_ready = 1'b0;
    for (int i = 0; i < NREQ; i++) set_req(i, mk_ir(OP_ADDI, '0, '0), 32'd40 + 32'(i), 32'd0, 32'd0, 32'd40 + 32'(i));
`ifdef RFPHOENIX_ALU_ARB_OUTREG_EN
    req_valid = 4'b1001;
`else
    req_valid = 4'b0001;
`endif
    serve(3, 1'b0);
    acc_q.delete();
    req_valid[1] = 1'b1;
    serve(2, 1'b0);
    req_valid[3] = 1'b1;
    serve(2, 1'b0);
    chk("stall_none_accepted", 64'(acc_q.size()), 64'd0);
    res_ready = 1'b1;
    serve(6, 1'b0);
    chk("stall_count", 64'(acc_q.size()), 64'd2);
    if (acc_q.size() == 2) begin
      chk("stall_first", 64'(acc_q[0]), 64'd1);
      chk("stall_second", 64'(acc_q[1]), 64'd3);
    end
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rfphoenix_alu_arb.md
# rfphoenix_alu_arb

Round-robin arbiter and two-stage issue pipeline that shares one integer/FP-compare ALU among `NREQ` requesters, typically thread slots of the SIMT scheduler. It accepts operand bundles over a valid/ready handshake and drives the ALU input ports from a registered issue stage. It returns each result tagged with the requester index and supports result backpressure. It also generates the single-cycle trace-queue pop strobe that POPQ side-effects require.

## Interface
- `NREQ`, 4, number of requesters (2..16)
- `TAGW`, `$clog2(NREQ)`, requester tag width
- `clk`  in  1  clock, all state on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `req_valid`  in  NREQ  requester i presents a bundle
- `req_ready`  out  NREQ  bundle i accepted on this edge when also valid
- `req_ir`  in  NREQ×instruction_t  instruction per requester
- `req_a`, `req_b`, `req_c`, `req_t`, `req_imm`  in  NREQ×value_t each  operands per requester
- `alu_ir`  out  instruction_t  registered issue-stage instruction to ALU
- `alu_a`, `alu_b`, `alu_c`, `alu_t`, `alu_imm`  out  value_t each  registered operands to ALU
- `alu_o`  in  value_t  combinational ALU result
- `res_valid`  out  1  result available
- `res_ready`  in  1  consumer accepts result
- `res_tag`  out  TAGW  index of the requester that owns the result
- `res_o`  out  value_t  result
- `trace_pop`  out  1  one-cycle pop strobe to the trace queue

## Operation
- Issue stage S1 holds `s1_v`, tag, ir, and operands. The ALU operates combinationally on S1.
- Grant goes to the first `req_valid[i]` strictly after `last_grant`, in modulo-NREQ order. At most one `req_ready` bit is high in any cycle.
- `req_ready[g] = grant[g] & s1_adv`. `s1_adv` is true when S1 is empty or S1 retires this cycle.
- `last_grant` updates only on an accepted transfer, so a requester that is stalled does not lose its turn.
- S1 retires when its result moves downstream:
  - With output register: the output register is empty or `res_ready` is high.
  - Without output register: `res_ready` is high.
- `trace_pop` is high for exactly one cycle per POPQ when both hold:
  - S1 holds opcode OP_R2 / func OP_R1 / Rb OP_POPQ with `imm[3:0]==15`.
  - S1 retires that cycle.
- A stalled POPQ never repeats the strobe. PEEKQ and STATQ never pop.
- Operands pass through unmodified, with no width conversion.

## Timing
- Reset values:
  - `req_ready=0`, `res_valid=0`, `res_tag=0`, `res_o=0`, `trace_pop=0`
  - `alu_*=0`, `s1_v=0`, `last_grant=NREQ-1` (so requester 0 wins first)
- Reset asserted mid-operation discards S1 and the output register. No pop is emitted.
- Latency, for a bundle accepted at edge n:
  - With output register: `res_valid` high in cycle n+2.
  - Without output register: `res_valid` high in cycle n+1.
- Throughput is one bundle per cycle with `res_ready` held high.
- Backpressure with `res_ready` low and both stages full:
  - `req_ready` is all zero.
  - S1 and `res_*` hold stable.
- `res_valid`/`res_o`/`res_tag` remain stable until the handshake edge `res_valid & res_ready`.
- Simultaneous drain and fill: the output register unloads and reloads on the same edge with no bubble.
- Simultaneous requests: round-robin only. A requester that drops `req_valid` before acceptance is skipped.

## Configuration
- `RFPHOENIX_ALU_ARB_OUTREG_EN` defined:
  - The result is captured in the output register; `res_o`/`res_tag` are flop outputs.
  - Latency is 2.
  - S1 may refill while the output register waits.
- Undefined:
  - `res_valid = s1_v`, `res_o = alu_o`, `res_tag` = S1 tag.
  - Latency is 1.
  - S1 stalls directly on `res_ready`.

## Test plan
- Single requester: req 2 issues ADDI with a=5, imm=7, `res_ready=1` → `res_o=12`, `res_tag=2`. `res_valid` high at n+2 (OUTREG) or n+1 (no OUTREG), for one cycle.
- Fairness: all 4 requesters continuously valid for 8 cycles → grant order 0,1,2,3,0,1,2,3, with no cycle lacking a grant.
- Backpressure: hold `res_ready=0` for 5 cycles with 3 requests pending:
  - At most 2 (OUTREG) or 1 (no OUTREG) bundles are accepted.
  - `res_o` stays stable.
  - When `res_ready` releases, results drain in grant order.
- POPQ: POPQ with `imm=15` stalled 3 cycles by `res_ready=0` → `trace_pop` pulses once, on the retire cycle. POPQ with `imm=3` → no pulse. PEEKQ with `imm=15` → no pulse.
- Reset mid-flight: assert `rst_n=0` while both stages are full → all outputs 0 immediately. After release, requester 0 is granted first.
- Stalled requester: req 1 valid while the pipe is stalled, req 3 arrives later → req 1 is granted first after the stall clears.
